fsm_processador: RTL and testbench

- Processor-side handshake controller that streams 16-bit data words over a shared bus `dado` to two peripherals.
- It alternates between peripheral 1 and peripheral 2, using an independent 2-bit four-phase send/ack handshake with each.
- The peripherals run on unrelated clocks, so every ack input is synchronized before use.
- It is the master side of the processor–peripheral link.

---
 rtl/fsm_processador.sv | 155 +++++++++++++++
 tb/tb_fsm_processador.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_processador.sv
// Processor-side four-phase handshake master streaming words to two peripherals.
// Alternates peripheral 1 and 2; ack inputs are synchronized before use.
module fsm_processador #(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ack,
  input  logic [1:0]        ack2,
  output logic [1:0]        send,
  output logic [1:0]        send2,
  output logic [DATA_W-1:0] dado
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] SND_IDLE  = 2'b00;
  localparam logic [1:0] SND_REQ   = 2'b01;
  localparam logic [1:0] SND_ABORT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_REL,
    S_ABT,
    S_NEXT
  } state_e;

  logic [SS-1:0][1:0] sync1_q;
  logic [SS-1:0][1:0] sync2_q;
  logic [1:0]         ack_s;
  logic [1:0]         ack2_s;
  logic [1:0]         ack_sel;

  state_e             state_q, state_d;
  logic               peer_q, peer_d;
  logic               ok_q, ok_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [DATA_W-1:0]  dado_q, dado_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic [1:0]         send_q, send_d;
  logic [1:0]         send2_q, send2_d;
  logic [1:0]         sreq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sync1_q[SS-2:0], ack};
      sync2_q <= {sync2_q[SS-2:0], ack2};
    end
  end

  assign ack_s   = sync1_q[SS-1];
  assign ack2_s  = sync2_q[SS-1];
  assign ack_sel = peer_q ? ack2_s : ack_s;

  always_comb begin
    state_d = state_q;
    peer_d  = peer_q;
    ok_d    = ok_q;
    word_d  = word_q;
    dado_d  = dado_q;
    wait_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_SETUP;
        peer_d  = 1'b0;
        dado_d  = word_q;
      end
      S_SETUP: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        wait_d = wait_q + WW'(1);
        if (ack_sel == 2'b01) begin
          state_d = S_REL;
          ok_d    = 1'b1;
          wait_d  = '0;
        end else if (ack_sel[1]) begin
          state_d = S_REL;
          ok_d    = 1'b0;
          wait_d  = '0;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          state_d = S_ABT;
          ok_d    = 1'b0;
          wait_d  = '0;
        end
      end
      S_REL: begin
        wait_d = wait_q + WW'(1);
        if (ack_sel == 2'b00) begin
          state_d = S_NEXT;
          wait_d  = '0;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          state_d = S_ABT;
          ok_d    = 1'b0;
          wait_d  = '0;
        end
      end
      S_ABT: begin
        state_d = S_NEXT;
        ok_d    = 1'b0;
      end
      S_NEXT: begin
        // a rejected word is re-offered to the other peripheral
        word_d  = ok_q ? word_q + DATA_W'(1) : word_q;
        dado_d  = word_d;
        peer_d  = ~peer_q;
        state_d = S_SETUP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    sreq = SND_IDLE;
    if (state_d == S_REQ) sreq = SND_REQ;
    if (state_d == S_ABT) sreq = SND_ABORT;
    send_d  = peer_d ? SND_IDLE : sreq;
    send2_d = peer_d ? sreq : SND_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      peer_q  <= 1'b0;
      ok_q    <= 1'b0;
      word_q  <= '0;
      dado_q  <= '0;
      wait_q  <= '0;
      send_q  <= SND_IDLE;
      send2_q <= SND_IDLE;
    end else begin
      state_q <= state_d;
      peer_q  <= peer_d;
      ok_q    <= ok_d;
      word_q  <= word_d;
      dado_q  <= dado_d;
      wait_q  <= wait_d;
      send_q  <= send_d;
      send2_q <= send2_d;
    end
  end

  assign send  = send_q;
  assign send2 = send2_q;
  assign dado  = dado_q;

endmodule

// File: tb/tb_fsm_processador.sv
// Bench for fsm_processador: random-delay peripheral models plus a
// word/peer sequence model; a narrow second instance exercises wrap.
module tb_fsm_processador;

  localparam int TO = 255;
  localparam int M_ACK = 0;
  localparam int M_NAK = 1;
  localparam int M_SIL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ack, ack2, send, send2;
  logic [15:0] dado;

  logic        rst_s = 1'b1;
  logic [1:0]  ack_m = 2'b00;
  logic [1:0]  ack2_m = 2'b00;
  logic [1:0]  send_m, send2_m;
  logic [3:0]  dado_m;

  always #5 clk = ~clk;

  fsm_processador #(.DATA_W(16), .TIMEOUT(TO), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ack(ack), .ack2(ack2),
    .send(send), .send2(send2), .dado(dado)
  );

  fsm_processador #(.DATA_W(4), .TIMEOUT(15), .SYNC_STAGES(2)) dut_small (
    .clk(clk), .rst(rst_s), .ack(ack_m), .ack2(ack2_m),
    .send(send_m), .send2(send2_m), .dado(dado_m)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // peripheral models and reference sequence model
  logic [1:0]  ackd [2] = '{2'b00, 2'b00};
  logic [1:0]  prev [2] = '{2'b00, 2'b00};
  logic [1:0]  resp [2];
  int          mode [2] = '{M_ACK, M_ACK};
  int          mode_l [2];
  int          dly [2];
  int          runlen [2];
  logic [15:0] start_w [2];
  logic [15:0] last_off [2];
  logic [15:0] prev_dado = '0;
  logic [15:0] exp_word = '0;
  int          exp_peer = 0;
  int          n_txn = 0;
  int          n_abort = 0;
  logic        last_ok = 1'b0;
  logic [16:0] caps [$];

  assign ack  = ackd[0];
  assign ack2 = ackd[1];

  always @(negedge clk) begin
    logic [1:0] cur;
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        ackd[p]   = 2'b00;
        prev[p]   = 2'b00;
        runlen[p] = 0;
      end
      exp_word  = '0;
      exp_peer  = 0;
      prev_dado = '0;
      caps.delete();
    end else begin
      chk("mutex", {31'd0, (send != 2'b00 && send2 != 2'b00)}, 0);
      for (int p = 0; p < 2; p++) begin
        cur = (p == 0) ? send : send2;
        if (prev[p] == 2'b00 && cur == 2'b01) begin
          chk("peer", p, exp_peer);
          chk("offer", dado, exp_word);
          chk("pre_stable", dado, prev_dado);
          start_w[p]  = dado;
          last_off[p] = dado;
          runlen[p]   = 1;
          mode_l[p]   = mode[p];
          dly[p]      = $urandom_range(0, 6);
          resp[p]     = 2'b00;
        end else if (prev[p] == 2'b01 && cur == 2'b01) begin
          runlen[p]++;
          chk("hold", dado, start_w[p]);
        end
        if (prev[p] == 2'b01 && cur != 2'b01) begin
          if (cur == 2'b11) begin
            chk("abort_after", runlen[p], TO);
            chk("abort_mode", mode_l[p], M_SIL);
            last_ok = 1'b0;
            n_abort++;
          end else begin
            chk("rel_enc", cur, 2'b00);
            last_ok = (resp[p] == 2'b01);
          end
          if (last_ok) exp_word = exp_word + 16'd1;
          exp_peer ^= 1;
          n_txn++;
        end
        if (prev[p] == 2'b11) chk("abort_len", cur, 2'b00);
        if (cur == 2'b01 && ackd[p] == 2'b00 && mode_l[p] != M_SIL) begin
          if (dly[p] > 0) begin
            dly[p]--;
          end else begin
            if (mode_l[p] == M_ACK) begin
              ackd[p] = 2'b01;
              caps.push_back({p[0], dado});
            end else begin
              ackd[p] = {1'b1, 1'($urandom_range(0, 1))};
            end
            resp[p] = ackd[p];
          end
        end else if (cur != 2'b01) begin
          ackd[p] = 2'b00;
        end
        prev[p] = cur;
      end
      prev_dado = dado;
    end
  end

  // narrow instance: always-ACK peripherals, counter wraps every 16 words
  logic [1:0] prev_m = 2'b00;
  logic [1:0] prev2_m = 2'b00;
  logic [3:0] exp_s = '0;
  logic [3:0] last_s = '0;
  int         n_s = 0;
  logic       wrap_seen = 1'b0;

  always @(negedge clk) begin
    if (!rst_s) begin
      if ((prev_m == 2'b00 && send_m == 2'b01) ||
          (prev2_m == 2'b00 && send2_m == 2'b01)) begin
        chk("s_offer", dado_m, exp_s);
        if (n_s > 0 && last_s == 4'hF) begin
          chk("s_wrap", dado_m, 4'h0);
          wrap_seen = 1'b1;
        end
        last_s = dado_m;
        exp_s  = exp_s + 4'd1;
        n_s++;
      end
      ack_m   = (send_m == 2'b01) ? 2'b01 : 2'b00;
      ack2_m  = (send2_m == 2'b01) ? 2'b01 : 2'b00;
      prev_m  = send_m;
      prev2_m = send2_m;
    end
  end

  task automatic wait_txn(input int k, input int budget);
    int target;
    int c;
    target = n_txn + k;
    c = 0;
    while (n_txn < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk("txn_timeout", {31'd0, n_txn >= target}, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic        found;
    int          na;

    repeat (3) @(negedge clk);
    chk("rst_send", send, 2'b00);
    chk("rst_send2", send2, 2'b00);
    chk("rst_dado", dado, 16'h0000);
    rst   = 1'b0;
    rst_s = 1'b0;
    @(negedge clk);
    chk("rel1_send", send, 2'b00);
    @(negedge clk);
    chk("rel2_send", send, 2'b01);
    chk("rel2_dado", dado, 16'h0000);

    @(posedge clk);
    wait_txn(4, 400);
    chk("cap_n", {31'd0, caps.size() >= 4}, 1);
    if (caps.size() >= 4) begin
      chk("cap0", caps[0], {1'b0, 16'h0000});
      chk("cap1", caps[1], {1'b1, 16'h0001});
      chk("cap2", caps[2], {1'b0, 16'h0002});
      chk("cap3", caps[3], {1'b1, 16'h0003});
    end

    mode[0] = M_NAK;
    wait_txn(1, 200);
    w = last_off[0];
    chk("nak_ok", {31'd0, last_ok}, 0);
    mode[0] = M_ACK;
    wait_txn(1, 200);
    chk("nak_p2", caps[$], {1'b1, w});
    wait_txn(1, 200);
    chk("nak_p1", caps[$], {1'b0, w + 16'd1});

    mode[1] = M_SIL;
    na = n_abort;
    wait_txn(1, 600);
    chk("abort_seen", n_abort, na + 1);
    w = last_off[1];
    mode[1] = M_ACK;
    wait_txn(1, 200);
    chk("abort_next", caps[$], {1'b0, w});

    repeat (30) begin
      mode[0] = ($urandom_range(0, 3) == 0) ? M_NAK : M_ACK;
      mode[1] = ($urandom_range(0, 3) == 0) ? M_NAK : M_ACK;
      wait_txn(1, 200);
    end

    mode[0] = M_ACK;
    mode[1] = M_ACK;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      #1;
      if (send == 2'b01 && ack == 2'b01) found = 1'b1;
    end
    chk("mid_found", {31'd0, found}, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_send", send, 2'b00);
    chk("mid_send2", send2, 2'b00);
    chk("mid_dado", dado, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    wait_txn(2, 300);
    chk("post_n", {31'd0, caps.size() >= 2}, 1);
    if (caps.size() >= 2) begin
      chk("post0", caps[0], {1'b0, 16'h0000});
      chk("post1", caps[1], {1'b1, 16'h0001});
    end

    chk("s_count", {31'd0, n_s >= 20}, 1);
    chk("s_wrap_seen", {31'd0, wrap_seen}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
